// File: rtl/friscv_rv32i_memfy.sv
// rtl/friscv_rv32i_memfy.sv - RV32I/RV64I load/store unit with a single-beat memory request port
//
// Purpose : Accepts one load/store instruction at a time. It computes the
//           effective address and rejects misaligned accesses with a one-cycle
//           error pulse. Otherwise it issues one lane-aligned memory request and,
//           for loads, writes the extracted and extended value back to the
//           register file.
// Ports   : aclk, areset (async, high), srst (sync, high)
//           memfy_*  instruction in (en/ready handshake), register write-back out,
//                    misaligned error pulse out
//           mem_*    memory request out (en/wr/addr/wdata/strb), rdata/ready in
module friscv_rv32i_memfy #(
    parameter int ADDRW = 16,
    parameter int XLEN  = 32
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                srst,
    input  logic                memfy_en,
    output logic                memfy_ready,
    input  logic [6:0]          memfy_opcode,
    input  logic [2:0]          memfy_funct3,
    input  logic [4:0]          memfy_rd,
    input  logic [11:0]         memfy_imm12,
    input  logic [XLEN-1:0]     memfy_rs1_val,
    input  logic [XLEN-1:0]     memfy_rs2_val,
    output logic                memfy_rd_wr,
    output logic [4:0]          memfy_rd_addr,
    output logic [XLEN-1:0]     memfy_rd_val,
    output logic                memfy_misaligned,
    output logic                mem_en,
    output logic                mem_wr,
    output logic [ADDRW-1:0]    mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_strb,
    input  logic [XLEN-1:0]     mem_rdata,
    input  logic                mem_ready
);

    localparam int NB = XLEN / 8;
    localparam int LW = $clog2(NB);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {IDLE, REQ, ERR} state_t;

    state_t          r_state;
    logic            r_is_load;
    logic [2:0]      r_funct3;
    logic [4:0]      r_rd;
    logic [LW-1:0]   r_lane;

    logic            w_is_load;
    logic            w_is_store;
    logic            w_legal;
    logic [ADDRW-1:0] w_ea;
    logic [LW-1:0]   w_lane;
    logic [3:0]      w_nbytes;
    logic [2:0]      w_amask;
    logic            w_misaligned;
    logic [NB-1:0]   w_strb;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_rdata_sh;
    logic [XLEN-1:0] w_load_val;

    // Decode and address generation for the instruction currently presented
    always_comb begin
        w_is_load  = (memfy_opcode == OP_LOAD);
        w_is_store = (memfy_opcode == OP_STORE);
        w_legal    = 1'b0;
        if (w_is_load) begin
            case (memfy_funct3)
                3'd0, 3'd1, 3'd2, 3'd4, 3'd5: w_legal = 1'b1;
                3'd3, 3'd6:                   w_legal = (XLEN == 64);
                default:                      w_legal = 1'b0;
            endcase
        end else if (w_is_store) begin
            case (memfy_funct3)
                3'd0, 3'd1, 3'd2: w_legal = 1'b1;
                3'd3:             w_legal = (XLEN == 64);
                default:          w_legal = 1'b0;
            endcase
        end
        w_ea         = ADDRW'(memfy_rs1_val + XLEN'($signed(memfy_imm12)));
        w_lane       = w_ea[LW-1:0];
        // funct3[1:0] encodes log2 of the access size for every load/store
        w_nbytes     = 4'd1 << memfy_funct3[1:0];
        w_amask      = 3'(w_nbytes - 4'd1);
        w_misaligned = |(w_ea[2:0] & w_amask);
        w_strb       = NB'((16'd1 << w_nbytes) - 16'd1) << w_lane;
        w_wdata      = memfy_rs2_val << {w_lane, 3'b000};
    end

    // Load data alignment and extension, driven by the captured instruction
    always_comb begin
        w_rdata_sh = mem_rdata >> {r_lane, 3'b000};
        case (r_funct3)
            3'd0:    w_load_val = XLEN'($signed(w_rdata_sh[7:0]));
            3'd1:    w_load_val = XLEN'($signed(w_rdata_sh[15:0]));
            3'd2:    w_load_val = XLEN'($signed(w_rdata_sh[31:0]));
            3'd4:    w_load_val = XLEN'(w_rdata_sh[7:0]);
            3'd5:    w_load_val = XLEN'(w_rdata_sh[15:0]);
            3'd6:    w_load_val = XLEN'(w_rdata_sh[31:0]);
            default: w_load_val = w_rdata_sh;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state          <= IDLE;
            r_is_load        <= 1'b0;
            r_funct3         <= '0;
            r_rd             <= '0;
            r_lane           <= '0;
            memfy_ready      <= 1'b0;
            memfy_rd_wr      <= 1'b0;
            memfy_rd_addr    <= '0;
            memfy_rd_val     <= '0;
            memfy_misaligned <= 1'b0;
            mem_en           <= 1'b0;
            mem_wr           <= 1'b0;
            mem_addr         <= '0;
            mem_wdata        <= '0;
            mem_strb         <= '0;
        end else if (srst) begin
            r_state          <= IDLE;
            r_is_load        <= 1'b0;
            r_funct3         <= '0;
            r_rd             <= '0;
            r_lane           <= '0;
            memfy_ready      <= 1'b0;
            memfy_rd_wr      <= 1'b0;
            memfy_rd_addr    <= '0;
            memfy_rd_val     <= '0;
            memfy_misaligned <= 1'b0;
            mem_en           <= 1'b0;
            mem_wr           <= 1'b0;
            mem_addr         <= '0;
            mem_wdata        <= '0;
            mem_strb         <= '0;
        end else begin
            memfy_rd_wr      <= 1'b0;
            memfy_misaligned <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Ready rises on the first edge after reset; illegal
                    // instructions are swallowed and ready stays high.
                    memfy_ready <= 1'b1;
                    if (memfy_en && memfy_ready && w_legal) begin
                        memfy_ready <= 1'b0;
                        if (w_misaligned) begin
                            r_state          <= ERR;
                            memfy_misaligned <= 1'b1;
                        end else begin
                            r_state   <= REQ;
                            r_is_load <= w_is_load;
                            r_funct3  <= memfy_funct3;
                            r_rd      <= memfy_rd;
                            r_lane    <= w_lane;
                            mem_en    <= 1'b1;
                            mem_wr    <= w_is_store;
                            mem_addr  <= {w_ea[ADDRW-1:LW], {LW{1'b0}}};
                            mem_wdata <= w_is_store ? w_wdata : '0;
                            mem_strb  <= w_strb;
                        end
                    end
                end
                REQ: begin
                    // mem_en is held for the whole REQ state, so mem_ready alone
                    // marks completion.
                    if (mem_ready) begin
                        r_state     <= IDLE;
                        mem_en      <= 1'b0;
                        memfy_ready <= 1'b1;
                        if (r_is_load && (r_rd != 5'd0)) begin
                            memfy_rd_wr   <= 1'b1;
                            memfy_rd_addr <= r_rd;
                            memfy_rd_val  <= w_load_val;
                        end
                    end
                end
                ERR: begin
                    r_state     <= IDLE;
                    memfy_ready <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/friscv_rv32i_memfy.md
FRISCV_RV32I_MEMFY -- requirements
Module: friscv_rv32i_memfy

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- ADDRW, 16, memory address width in bits (ADDRW >= 3).
- XLEN, 32, data width; legal values 32 or 64.
REQ-002 Ports, one per line: name, direction, width, meaning:
- aclk in 1: the design's single clock.
- areset in 1: asynchronous, active-high reset.
- srst in 1: synchronous reset, active high.
- memfy_en in 1: instruction valid.
- memfy_ready out 1: instruction accepted when memfy_en and memfy_ready are both high.
- memfy_opcode in 7: opcode.
- memfy_funct3 in 3: width and sign selector.
- memfy_rd in 5: destination register.
- memfy_imm12 in 12: signed offset.
- memfy_rs1_val in XLEN: base address.
- memfy_rs2_val in XLEN: store data.
- memfy_rd_wr out 1: register write strobe.
- memfy_rd_addr out 5: register write address.
- memfy_rd_val out XLEN: register write data.
- memfy_misaligned out 1: misalignment error pulse.
- mem_en out 1: memory request valid.
- mem_wr out 1: 1 = write, 0 = read.
- mem_addr out ADDRW: XLEN/8-aligned byte address.
- mem_wdata out XLEN: lane-shifted write data.
- mem_strb out XLEN/8: byte enables.
- mem_rdata in XLEN: read data.
- mem_ready in 1: memory completes the request in the cycle it is high while mem_en is high.

Function
REQ-003 Supported instructions:
- LOAD (7'b0000011): funct3 LB=0, LH=1, LW=2, LBU=4, LHU=5, plus LD=3 and LWU=6 when XLEN=64.
- STORE (7'b0100011): funct3 SB=0, SH=1, SW=2, plus SD=3 when XLEN=64.
REQ-004 Any other opcode or funct3 accepted while memfy_en is high is consumed with no side effect; memfy_ready stays high.
REQ-005 Effective address EA = memfy_rs1_val + sign-extended memfy_imm12, modulo 2^XLEN, truncated to ADDRW bits.
REQ-006 mem_addr is EA with the low log2(XLEN/8) bits cleared. Byte lane offset = those cleared bits.
REQ-007 Access size is 1, 2, 4 or 8 bytes. An access is misaligned when EA mod size is not 0.
REQ-008 State machine has three states: IDLE, REQ and ERR.
- memfy_ready is high only in IDLE.
- A legal, aligned load/store accepted in IDLE goes to REQ.
- A misaligned load/store goes to ERR.
- REQ returns to IDLE in the cycle after mem_en and mem_ready are both high.
- ERR returns to IDLE after exactly one cycle.
REQ-009 All mem_* and memfy_* outputs are registered. Operands are captured on acceptance, so the instruction inputs may change after the handshake.
REQ-010 mem_en rises the cycle after acceptance and is held high, with mem_addr, mem_wr, mem_wdata and mem_strb stable, until mem_ready is sampled high.
REQ-011 Store data: mem_wdata = rs2_val shifted left by 8 × lane offset. mem_strb has size consecutive ones starting at the lane offset.
REQ-012 Loads drive mem_strb with the same lane mask; mem_wdata is 0 on loads.
REQ-013 Load result: take mem_rdata shifted right by 8 × lane offset, keep the low size bytes, then:
- sign-extend for LB, LH, LW (XLEN=64 only) and LD;
- zero-extend for LBU, LHU and LWU.
For LW with XLEN=32 the result is unmodified.
REQ-014 Loads pulse memfy_rd_wr for exactly one cycle, the cycle after mem_ready, with memfy_rd_addr = rd.
- A load with rd = 0 performs the memory read but never asserts memfy_rd_wr.
REQ-015 Latency with mem_ready high at first request (cycle 0 = acceptance):
- mem_en high in cycle 1.
- memfy_rd_wr high and memfy_ready high in cycle 2.
- Sustained throughput is one access per 2 cycles.
REQ-016 Misaligned access: no mem_en, no memfy_rd_wr. memfy_misaligned pulses one cycle in cycle 1; memfy_ready is high again in cycle 2.
REQ-017 memfy_rd_val holds its last value when memfy_rd_wr is low.

Reset
REQ-018 While areset is high, outputs are asynchronously forced to:
- memfy_ready=0, all other outputs = 0, state = IDLE.
REQ-019 memfy_ready rises the first clock edge after reset release.
REQ-020 srst high at a clock edge has the same effect as areset, synchronously.
REQ-021 Reset during REQ abandons the request: mem_en drops, and no memfy_rd_wr pulse is produced.

Verification
REQ-022 LW, XLEN=32, rs1=0x100, imm=0x004, mem_rdata=0xDEADBEEF, mem_ready high at once -> mem_addr=0x0104 and mem_strb=4'b1111 in cycle 1; memfy_rd_wr with rd_val=0xDEADBEEF in cycle 2.
REQ-023 LB and LBU at EA=0x0103, mem_rdata=0x80xxxxxx -> LB rd_val=0xFFFFFF80, LBU rd_val=0x00000080, mem_strb=4'b1000.
REQ-024 SH, rs2=0x1234ABCD, EA=0x0002 (rs1=0x10, imm=-14) -> mem_addr=0x0000, mem_wr=1, mem_strb=4'b1100, mem_wdata=0xABCD0000; mem_ready held low 3 cycles -> outputs stable, memfy_ready low until the cycle after mem_ready.
REQ-025 LW at EA=0x0102 -> memfy_misaligned pulse in cycle 1, mem_en never high, memfy_ready high in cycle 2.
REQ-026 LW with rd=0, and areset asserted while mem_en waits -> no memfy_rd_wr in either case; all outputs are 0 during reset.
REQ-027 XLEN=64, LD at EA=0x0008 and SD at EA=0x0008 -> mem_strb=8'hFF with full 64-bit data; LWU at EA=0x000C, rdata upper word=0x80000000 -> rd_val=0x0000000080000000.
